dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
Parametrised data memory for the RISC-V core's memory stage, replacing the flat word-only array. Adds byte/halfword/word stores with byte-lane masking, sign/zero-extended loads per RV32I funct3, a valid/ready request port with configurable wait states, and a registered response. Sits between the execute/memory pipeline stage and the writeback mux; the core stalls on req_ready/rsp_valid.

Parameters:
DEPTH_WORDS, 512, number of 32-bit words; power of two, at least 2.
ADDR_W, 32, byte-address width of req_addr.
WAIT_STATES, 0, extra cycles between acceptance and response (0..15).

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  block can accept a request this cycle.
req_we  input  1  1 = store, 0 = load.
req_funct3  input  3  RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
req_addr  input  ADDR_W  byte address.
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
rsp_valid  output  1  one-cycle pulse: access complete.
rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores.
rsp_err  output  1  access rejected; valid only with rsp_valid.

Behaviour:
- Reset (rst high at posedge): state IDLE, wait counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0. Memory contents are not cleared. req_ready = (state==IDLE) && !rst, so req_ready is 0 while rst is high.
- Reset mid-operation: the pending access is dropped, no write occurs, and no rsp_valid is produced.
- Handshake: a request is accepted on a posedge with req_valid && req_ready. Accepting latches req_we, req_funct3, req_addr and req_wdata. Input changes after acceptance are ignored.
- FSM:
  - IDLE -> WAIT on accept if WAIT_STATES>0; IDLE -> RESP on accept if WAIT_STATES==0.
  - WAIT counts WAIT_STATES cycles, then -> RESP.
  - RESP asserts rsp_valid for exactly 1 cycle, then -> IDLE.
- Latency: rsp_valid is high WAIT_STATES+1 cycles after the accept edge. Throughput is one access per WAIT_STATES+2 cycles (req_ready is low in WAIT and RESP).
- Addressing: word index = addr[2 +: log2(DEPTH_WORDS)]; lane = addr[1:0].
- Store execution: the write commits on the edge entering RESP. Lane mask is SB = 1 byte at the lane, SH = bytes {addr[1]*2, +1}, SW = all 4. Unmasked bytes are unchanged.
- Load execution: the memory word is sampled on the edge entering RESP, so it reflects all earlier completed stores. The selected byte/half is shifted to bit 0 and then extended: B/H sign-extended, BU/HU zero-extended, W unmodified.
- rsp_rdata holds its value until the next RESP; it is 0 after reset and 0 for stores.
- Only one access is outstanding at a time, so no read/write hazards exist inside the block.

Optional Feature:
Macro DMEM_ERR_EN.
- Defined: an access is an error if any of the following holds: misaligned (H/HU with addr[0]=1, W with addr[1:0]!=0); out of range (addr >= DEPTH_WORDS*4); or funct3 in {011,110,111}. An error access performs no write, returns rsp_rdata=0, and pulses rsp_err=1 with rsp_valid. Latency is unchanged.
- Undefined: rsp_err is tied 0. Misaligned accesses mask the low bits (H uses addr[1] only, W ignores addr[1:0]). Out-of-range addresses wrap modulo DEPTH_WORDS. Illegal funct3 codes behave as W.

Test Plan:
- Reset: hold rst 3 cycles with req_valid=1 -> req_ready=0, rsp_valid=0, rsp_rdata=0 throughout; req_ready=1 the first cycle after rst falls.
- Byte lanes: SW 0x11223344 @0x10, then SB 0xAA @0x12 -> LW @0x10 returns 0x11AA3344; SH 0xBEEF @0x10 -> LW returns 0x11AABEEF.
- Extension: word 0x80FF7F01 @0x20 -> LB @0x22 = 0xFFFFFFFF; LBU @0x22 = 0x000000FF; LH @0x22 = 0xFFFF80FF; LHU @0x22 = 0x000080FF; LB @0x20 = 0x00000001.
- Wait states: WAIT_STATES=3, accept at cycle 0 -> rsp_valid only at cycle 4; req_ready=0 in cycles 1-4; a back-to-back request is accepted at cycle 5.
- Reset mid-access: WAIT_STATES=3, SW 0xDEADBEEF @0x40, assert rst at cycle 2 -> no rsp_valid; a later LW @0x40 returns the prior contents.
- Errors: with DMEM_ERR_EN, LW @0x41 -> rsp_err=1, rdata 0; SW @0x800 (DEPTH 512) -> rsp_err=1 and memory unchanged. Without the macro, LW @0x41 returns the word at 0x40 and rsp_err=0.

Source files
------------

// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl: data memory for the core's memory stage.
//
// Byte-addressed view onto a DEPTH_WORDS x 32-bit array with RV32I store
// widths (SB/SH/SW via byte-lane masking) and load extension (LB/LH/LW/LBU/LHU).
// A single access is accepted through a valid/ready port, optionally held for
// WAIT_STATES cycles, then answered with a one-cycle registered response.
//
// Ports:
//   clk         system clock, all state on the rising edge
//   rst         synchronous active-high reset (memory contents are kept)
//   req_valid   request present
//   req_ready   block can accept a request this cycle (IDLE and not in reset)
//   req_we      1 = store, 0 = load
//   req_funct3  RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   req_addr    byte address
//   req_wdata   store data, right-aligned
//   rsp_valid   one-cycle pulse when the access completes
//   rsp_rdata   extended load result, 0 for stores; held until the next response
//   rsp_err     access rejected (only meaningful with rsp_valid)
//
// Build option:
//   DMEM_ERR_EN  when defined, misaligned, out-of-range and illegal-funct3
//                accesses are rejected with rsp_err. When undefined, rsp_err is
//                0, low address bits are masked, addresses wrap and illegal
//                funct3 codes act as word accesses.
// -----------------------------------------------------------------------------
module dmem_ctrl #(
    parameter int unsigned DEPTH_WORDS = 512,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned IdxW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WaitCntInit = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    // FSM and latched request
    state_e             state_q, state_d;
    logic [3:0]         wait_cnt_q, wait_cnt_d;
    logic               we_q, we_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;

    // Registered response
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;

    logic [31:0]        mem_q [DEPTH_WORDS];

    logic               accept;
    logic               enter_resp;

    // Fields of the access being executed. With no wait states the access
    // executes on the accept edge itself, so the live request is used there.
    logic               acc_we;
    logic [2:0]         acc_funct3;
    logic [ADDR_W-1:0]  acc_addr;
    logic [31:0]        acc_wdata;
    logic [IdxW-1:0]    acc_idx;
    logic [1:0]         acc_lane;
    logic               acc_sext;
    logic               acc_err;

    logic [3:0]         wr_be;
    logic [31:0]        wr_data;
    logic               mem_we;
    logic [31:0]        rd_word;
    logic [4:0]         rd_shift;
    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic [31:0]        ld_data;

    assign req_ready = (state_q == StIdle) && !rst;
    assign accept    = req_valid && req_ready;

    always_comb begin
        if (state_q == StIdle) begin
            acc_we     = req_we;
            acc_funct3 = req_funct3;
            acc_addr   = req_addr;
            acc_wdata  = req_wdata;
        end else begin
            acc_we     = we_q;
            acc_funct3 = funct3_q;
            acc_addr   = addr_q;
            acc_wdata  = wdata_q;
        end
    end

    assign acc_idx  = acc_addr[2 +: IdxW];
    assign acc_lane = acc_addr[1:0];
    assign acc_sext = !acc_funct3[2];

`ifdef DMEM_ERR_EN
    localparam logic [ADDR_W:0] AddrLimit = (ADDR_W + 1)'(DEPTH_WORDS) << 2;

    always_comb begin
        acc_err = 1'b0;
        if (acc_funct3 == 3'b011 || acc_funct3 == 3'b110 || acc_funct3 == 3'b111) begin
            acc_err = 1'b1;
        end
        if (acc_funct3[1:0] == 2'b01 && acc_addr[0]) begin
            acc_err = 1'b1;
        end
        if (acc_funct3[1:0] == 2'b10 && acc_addr[1:0] != 2'b00) begin
            acc_err = 1'b1;
        end
        if ({1'b0, acc_addr} >= AddrLimit) begin
            acc_err = 1'b1;
        end
    end
`else
    assign acc_err = 1'b0;

    // Upper address bits are ignored: addresses wrap modulo the array size.
    logic unused_addr_hi;
    assign unused_addr_hi = ^acc_addr[ADDR_W-1:IdxW+2];
`endif

    // Width decode uses funct3[1:0]; 11 (and the illegal 110) fall to word.
    always_comb begin
        rd_word  = mem_q[acc_idx];
        rd_shift = {acc_lane, 3'b000};
        rd_byte  = rd_word[rd_shift +: 8];
        rd_half  = acc_lane[1] ? rd_word[31:16] : rd_word[15:0];
        wr_be    = 4'b1111;
        wr_data  = acc_wdata;
        ld_data  = rd_word;
        case (acc_funct3[1:0])
            2'b00: begin
                wr_be   = 4'b0001 << acc_lane;
                wr_data = {4{acc_wdata[7:0]}};
                ld_data = {{24{acc_sext & rd_byte[7]}}, rd_byte};
            end
            2'b01: begin
                wr_be   = acc_lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{acc_wdata[15:0]}};
                ld_data = {{16{acc_sext & rd_half[15]}}, rd_half};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_data = acc_wdata;
                ld_data = rd_word;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    if (WAIT_STATES == 0) begin
                        state_d = StResp;
                    end else begin
                        state_d    = StWait;
                        wait_cnt_d = WaitCntInit;
                    end
                end
            end
            StWait: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // The access executes on the edge that enters RESP.
        if (state_d == StResp) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = acc_err;
            rsp_rdata_d = (acc_we || acc_err) ? 32'd0 : ld_data;
        end
    end

    // RESP always leaves after one cycle, so state_d == StResp marks entry.
    assign enter_resp = (state_d == StResp);
    assign mem_we     = enter_resp && acc_we && !acc_err && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            wait_cnt_q  <= 4'd0;
            we_q        <= 1'b0;
            funct3_q    <= 3'd0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem_q[acc_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_ctrl: scoreboard bench for dmem_ctrl (WAIT_STATES = 3, 512 words).
// Stimulus pushes the expected {err, rdata} on each accepted request; a monitor
// pops and compares on every rsp_valid. Error-path expectations follow
// DMEM_ERR_EN.
// -----------------------------------------------------------------------------
module tb_dmem_ctrl;

    localparam int unsigned Depth = 512;
    localparam int unsigned Ws    = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [32:0] exp_q[$];
    logic        prev_valid = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_ctrl #(
        .DEPTH_WORDS (Depth),
        .ADDR_W      (32),
        .WAIT_STATES (Ws)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every response must be expected, single-cycle and match.
    always @(negedge clk) begin
        logic [32:0] e;
        if (rsp_valid) begin
            check("rsp_single_pulse", {31'd0, prev_valid}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rdata %h err %b, expected no response",
                         rsp_rdata, rsp_err);
            end else begin
                e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, e[31:0]);
                check("rsp_err", {31'd0, rsp_err}, {31'd0, e[32]});
            end
        end
        prev_valid = rsp_valid;
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                         input bit push, output int acc_cyc);
        int n;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req_ready %b, expected 1 within 100 cycles", req_ready);
            req_valid = 1'b0;
            acc_cyc   = -1;
        end else begin
            if (push) exp_q.push_back({exp_err, exp_rd});
            @(posedge clk);
            #1;
            acc_cyc = cyc;
            // Scramble inputs: the DUT must work from its latched copy.
            req_valid  = 1'b0;
            req_we     = ~we;
            req_funct3 = 3'b111;
            req_addr   = $urandom;
            req_wdata  = $urandom;
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("pending_responses", exp_q.size(), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int b;

        // Reset held 3 cycles with a request pending.
        rst        = 1'b1;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        req_wdata  = 32'hFFFF_FFFF;
        repeat (3) begin
            @(negedge clk);
            check("rst_req_ready", {31'd0, req_ready}, 32'd0);
            check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            check("rst_rsp_rdata", rsp_rdata, 32'd0);
            check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {31'd0, req_ready}, 32'd1);

        // Byte lanes
        issue(1'b1, 3'b010, 32'h10, 32'h1122_3344, 32'h0, 1'b0, 1'b1, a);
        issue(1'b1, 3'b000, 32'h12, 32'h1234_56AA, 32'h0, 1'b0, 1'b1, a);
        issue(1'b0, 3'b010, 32'h10, 32'h0,         32'h11AA_3344, 1'b0, 1'b1, a);
        issue(1'b1, 3'b001, 32'h10, 32'h9999_BEEF, 32'h0, 1'b0, 1'b1, a);

        // Wait-state timing on LW @0x10, then a back-to-back request.
        issue(1'b0, 3'b010, 32'h10, 32'h0, 32'h11AA_BEEF, 1'b0, 1'b1, a);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("ws_req_ready", {31'd0, req_ready}, 32'd0);
            check("ws_rsp_valid", {31'd0, rsp_valid}, (j == 3) ? 32'd1 : 32'd0);
        end
        issue(1'b1, 3'b010, 32'h20, 32'h80FF_7F01, 32'h0, 1'b0, 1'b1, b);
        check("b2b_accept_gap", b - a, 32'd5);

        // Load extension on 0x80FF7F01 @0x20
        issue(1'b0, 3'b000, 32'h22, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b1, a);
        issue(1'b0, 3'b100, 32'h22, 32'h0, 32'h0000_00FF, 1'b0, 1'b1, a);
        issue(1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF_80FF, 1'b0, 1'b1, a);
        issue(1'b0, 3'b101, 32'h22, 32'h0, 32'h0000_80FF, 1'b0, 1'b1, a);
        issue(1'b0, 3'b000, 32'h20, 32'h0, 32'h0000_0001, 1'b0, 1'b1, a);
        issue(1'b0, 3'b000, 32'h23, 32'h0, 32'hFFFF_FF80, 1'b0, 1'b1, a);
        issue(1'b0, 3'b001, 32'h20, 32'h0, 32'h0000_7F01, 1'b0, 1'b1, a);

        // Reset in the middle of a store: no response, no write.
        issue(1'b1, 3'b010, 32'h40, 32'h0102_0304, 32'h0, 1'b0, 1'b1, a);
        issue(1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, a);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("rst_mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        check("rst_mid_rdata_cleared", rsp_rdata, 32'd0);
        issue(1'b0, 3'b010, 32'h40, 32'h0, 32'h0102_0304, 1'b0, 1'b1, a);

`ifdef DMEM_ERR_EN
        issue(1'b0, 3'b010, 32'h41,  32'h0,         32'h0, 1'b1, 1'b1, a);
        issue(1'b1, 3'b010, 32'h0,   32'hCAFE_F00D, 32'h0, 1'b0, 1'b1, a);
        issue(1'b1, 3'b010, 32'h800, 32'h1234_5678, 32'h0, 1'b1, 1'b1, a);
        issue(1'b0, 3'b010, 32'h0,   32'h0,         32'hCAFE_F00D, 1'b0, 1'b1, a);
        issue(1'b0, 3'b011, 32'h10,  32'h0,         32'h0, 1'b1, 1'b1, a);
        issue(1'b0, 3'b001, 32'h11,  32'h0,         32'h0, 1'b1, 1'b1, a);
`else
        issue(1'b0, 3'b010, 32'h41,  32'h0,         32'h0102_0304, 1'b0, 1'b1, a);
        issue(1'b1, 3'b010, 32'h800, 32'h1234_5678, 32'h0, 1'b0, 1'b1, a);
        issue(1'b0, 3'b010, 32'h0,   32'h0,         32'h1234_5678, 1'b0, 1'b1, a);
        issue(1'b0, 3'b011, 32'h10,  32'h0,         32'h11AA_BEEF, 1'b0, 1'b1, a);
        issue(1'b0, 3'b001, 32'h11,  32'h0,         32'hFFFF_BEEF, 1'b0, 1'b1, a);
`endif

        wait_done();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
